// File: rtl/apb_pkg.sv
// Shared APB completer definitions: transfer FSM states and byte-to-word index shift.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } apb_state_e;

  localparam int unsigned WordShift = 2;

endpackage

// File: rtl/apb_reg_slave.sv
// APB-style register completer: NR_REGS words, the top one a read-only status input,
// with programmable access wait states, abort on early sel drop and per-register write strobes.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int unsigned NR_REGS     = 8,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sel,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic                          wr_rd,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          ready,
  input  logic [DATA_WIDTH-1:0]         status,
  output logic [NR_REGS*DATA_WIDTH-1:0] regs,
  output logic [NR_REGS-1:0]            wr_pulse
);

  localparam int unsigned IdxWidth  = ADDR_WIDTH - WordShift;
  localparam int unsigned StatusIdx = NR_REGS - 1;

  apb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IdxWidth-1:0]   idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [DATA_WIDTH-1:0] regs_q [NR_REGS];
  logic [NR_REGS-1:0]    wr_onehot;
  logic [NR_REGS-1:0]    wr_pulse_q;

  // Byte lane bits carry no meaning for word registers.
  logic unused_addr;
  assign unused_addr = ^addr[WordShift-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel) begin
          state_d = StSetup;
          idx_d   = addr[ADDR_WIDTH-1:WordShift];
          wr_d    = wr_rd;
          wdata_d = wdata;
        end
      end
      StSetup: begin
        if (sel) begin
          state_d = StAccess;
          cnt_d   = 4'(WAIT_STATES);
        end else begin
          state_d = StIdle;
        end
      end
      StAccess: begin
        // Once the counter hits zero the transfer completes regardless of sel.
        if (cnt_q == '0) begin
          ready   = 1'b1;
          state_d = StIdle;
        end else if (!sel) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  // Only indices below the status slot are writable; others complete silently.
  always_comb begin
    wr_onehot = '0;
    if (ready && wr_q) begin
      for (int unsigned i = 0; i < StatusIdx; i++) begin
        if (32'(idx_q) == i) wr_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NR_REGS; i++) regs_q[i] <= '0;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= wr_onehot;
      for (int unsigned i = 0; i < NR_REGS; i++) begin
        if (wr_onehot[i]) regs_q[i] <= wdata_q;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (ready && !wr_q) begin
      if (32'(idx_q) == StatusIdx) begin
        rdata = status;
      end else begin
        for (int unsigned i = 0; i < StatusIdx; i++) begin
          if (32'(idx_q) == i) rdata = regs_q[i];
        end
      end
    end
  end

  always_comb begin
    regs = '0;
    for (int unsigned i = 0; i < NR_REGS; i++) begin
      regs[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: dut0 has no wait states and a 6-bit address
// (reaches out-of-range indices), dut1 has three wait states and the default address width.
module tb_apb_reg_slave;

  localparam int unsigned NrRegs = 8;

  typedef struct {
    logic        wr;
    int unsigned idx;
    logic [31:0] data;
    logic [7:0]  pulse;
    int          exp_cyc;
  } item_t;

  logic                  clk = 1'b0;
  logic [1:0]            rst_n = 2'b00;
  logic [1:0]            sel = 2'b00;
  logic [1:0][5:0]       addr = '0;
  logic [1:0]            wr_rd = 2'b00;
  logic [1:0][31:0]      wdata = '0;
  logic [1:0][31:0]      status = '0;
  logic [1:0][31:0]      rdata;
  logic [1:0]            ready;
  logic [1:0][255:0]     regs;
  logic [1:0][7:0]       wr_pulse;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model [2][NrRegs];
  logic [7:0]  pulse_exp [2];
  item_t       q0[$];
  item_t       q1[$];

  apb_reg_slave #(
    .NR_REGS    (8),
    .ADDR_WIDTH (6),
    .DATA_WIDTH (32),
    .WAIT_STATES(0)
  ) dut0 (
    .clk     (clk),
    .rst_n   (rst_n[0]),
    .sel     (sel[0]),
    .addr    (addr[0]),
    .wr_rd   (wr_rd[0]),
    .wdata   (wdata[0]),
    .rdata   (rdata[0]),
    .ready   (ready[0]),
    .status  (status[0]),
    .regs    (regs[0]),
    .wr_pulse(wr_pulse[0])
  );

  apb_reg_slave #(
    .NR_REGS    (8),
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32),
    .WAIT_STATES(3)
  ) dut1 (
    .clk     (clk),
    .rst_n   (rst_n[1]),
    .sel     (sel[1]),
    .addr    (addr[1][4:0]),
    .wr_rd   (wr_rd[1]),
    .wdata   (wdata[1]),
    .rdata   (rdata[1]),
    .ready   (ready[1]),
    .status  (status[1]),
    .regs    (regs[1]),
    .wr_pulse(wr_pulse[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void qpush(input int i, input item_t it);
    if (i == 0) q0.push_back(it);
    else q1.push_back(it);
  endfunction

  function automatic item_t qpop(input int i);
    return (i == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  function automatic void qdrop(input int i);
    if (i == 0) q0.delete();
    else q1.delete();
  endfunction

  task automatic check(input int i, input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL dut%0d %s: got %0h expected %0h (cycle %0d)", i, name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int i);
    item_t        it;
    logic [255:0] exp_regs;
    if (!rst_n[i]) return;
    for (int k = 0; k < NrRegs; k++) exp_regs[k*32 +: 32] = model[i][k];
    check(i, "regs", regs[i], exp_regs);
    check(i, "wr_pulse", 256'(wr_pulse[i]), 256'(pulse_exp[i]));
    pulse_exp[i] = '0;
    if (ready[i]) begin
      if (qsize(i) == 0) begin
        checks++;
        failures++;
        $display("FAIL dut%0d unexpected_ready: got ready=1 expected no transfer (cycle %0d)",
                 i, cyc);
      end else begin
        it = qpop(i);
        check(i, "latency", 256'(cyc), 256'(it.exp_cyc));
        if (!it.wr) begin
          check(i, "rdata", 256'(rdata[i]), 256'(it.data));
        end else if (it.pulse != '0) begin
          model[i][it.idx] = it.data;
          pulse_exp[i]     = it.pulse;
        end
      end
    end else begin
      check(i, "rdata_idle", 256'(rdata[i]), 256'(0));
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic scramble(input int i);
    addr[i]  = 6'($urandom);
    wr_rd[i] = 1'($urandom);
    wdata[i] = $urandom;
  endtask

  // Called just after a rising edge; returns just after a later rising edge with sel still
  // high for a completed transfer (caller decides back-to-back or drop) or low after an abort.
  task automatic xfer(input int i, input logic [5:0] a, input logic w, input logic [31:0] d,
                      input int abort_k);
    item_t       it;
    int unsigned idx;
    int          start;
    bit          done;
    sel[i]   = 1'b1;
    addr[i]  = a;
    wr_rd[i] = w;
    wdata[i] = d;
    start    = cyc;
    idx      = (i == 0) ? int'(a[5:2]) : int'(a[4:2]);
    if (abort_k > 0) begin
      repeat (abort_k) begin
        @(posedge clk);
        #1;
        scramble(i);
      end
      sel[i] = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    it.wr      = w;
    it.idx     = idx;
    it.exp_cyc = start + 2 + wait_of(i);
    it.pulse   = '0;
    if (w) begin
      it.data = d;
      if (idx < NrRegs - 1) it.pulse = 8'(1 << idx);
    end else if (idx < NrRegs - 1) begin
      it.data = model[i][idx];
    end else if (idx == NrRegs - 1) begin
      it.data = status[i];
    end else begin
      it.data = '0;
    end
    qpush(i, it);
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (ready[i]) begin
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        scramble(i);
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL dut%0d timeout: got no ready expected ready at cycle %0d", i, it.exp_cyc);
      qdrop(i);
      sel[i] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int i;
    int k;
    int burst;
    logic [5:0] a;
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < NrRegs; r++) model[d][r] = '0;
      pulse_exp[d] = '0;
    end

    #2;
    for (int d = 0; d < 2; d++) begin
      check(d, "reset_ready", 256'(ready[d]), 256'(0));
      check(d, "reset_rdata", 256'(rdata[d]), 256'(0));
      check(d, "reset_regs", regs[d], 256'(0));
      check(d, "reset_pulse", 256'(wr_pulse[d]), 256'(0));
    end
    idle(3);
    rst_n = 2'b11;
    idle(2);

    // Zero-wait write then read-back.
    xfer(0, 6'h04, 1'b1, 32'hDEADBEEF, 0);
    sel[0] = 1'b0;
    check(0, "write_regs1", 256'(regs[0][63:32]), 256'(32'hDEADBEEF));
    check(0, "write_pulse", 256'(wr_pulse[0]), 256'(8'b0000_0010));
    idle(1);
    xfer(0, 6'h04, 1'b0, 32'h0, 0);
    sel[0] = 1'b0;
    idle(1);

    // Three-wait read, status read, ignored status write, then out-of-range on dut0.
    xfer(1, 6'h00, 1'b0, 32'h0, 0);
    sel[1]    = 1'b0;
    status[1] = 32'h12345678;
    idle(1);
    xfer(1, 6'h1C, 1'b0, 32'h0, 0);
    xfer(1, 6'h1C, 1'b1, 32'hFFFFFFFF, 0);
    sel[1] = 1'b0;
    xfer(0, 6'h24, 1'b1, 32'h0BAD0BAD, 0);
    xfer(0, 6'h24, 1'b0, 32'h0, 0);
    sel[0] = 1'b0;

    // Abort in second access cycle, then confirm the FSM accepts a normal transfer.
    xfer(1, 6'h08, 1'b1, 32'h5A5A5A5A, 3);
    xfer(1, 6'h08, 1'b0, 32'h0, 0);
    sel[1] = 1'b0;
    idle(1);

    for (int t = 0; t < 40; t++) begin
      i     = $urandom_range(0, 1);
      burst = $urandom_range(1, 4);
      for (int b = 0; b < burst; b++) begin
        status[i] = $urandom;
        if (i == 0) a = {4'($urandom_range(0, 9)), 2'($urandom)};
        else a = {1'b0, 3'($urandom), 2'($urandom)};
        k = ($urandom_range(0, 5) == 0) ? $urandom_range(1, wait_of(i) + 1) : 0;
        xfer(i, a, 1'($urandom), $urandom, k);
      end
      sel[i] = 1'b0;
      idle($urandom_range(0, 2));
    end

    // Reset in the middle of an access phase.
    xfer(1, 6'h0C, 1'b1, 32'h11112222, 0);
    sel[1] = 1'b0;
    idle(1);
    sel[1]   = 1'b1;
    addr[1]  = 6'h0C;
    wr_rd[1] = 1'b1;
    wdata[1] = 32'hA5A5A5A5;
    idle(3);
    rst_n[1] = 1'b0;
    #1;
    check(1, "rst_ready", 256'(ready[1]), 256'(0));
    check(1, "rst_rdata", 256'(rdata[1]), 256'(0));
    check(1, "rst_pulse", 256'(wr_pulse[1]), 256'(0));
    check(1, "rst_regs", regs[1], 256'(0));
    for (int r = 0; r < NrRegs; r++) model[1][r] = '0;
    pulse_exp[1] = '0;
    sel[1]       = 1'b0;
    idle(2);
    rst_n[1] = 1'b1;
    idle(2);
    check(1, "post_rst_regs3", 256'(regs[1][127:96]), 256'(0));
    xfer(1, 6'h0C, 1'b0, 32'h0, 0);
    sel[1] = 1'b0;
    idle(3);

    check(0, "queue_empty", 256'(qsize(0)), 256'(0));
    check(1, "queue_empty", 256'(qsize(1)), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected completion before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
